// File: rtl/morse_tx_sequencer_pkg.sv
// Shared Morse sequencer definitions: FSM states, special symbols, unit multiples
// and helpers that split a sentinel-encoded symbol into its element bits.
package morse_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ELEM_ON,
    ST_ELEM_GAP,
    ST_CHAR_GAP,
    ST_WORD_GAP,
    ST_FIN
  } state_e;

  localparam logic [4:0] SYM_END   = 5'b00000;
  localparam logic [4:0] SYM_SPACE = 5'b00001;

  localparam logic [2:0] DOT_U        = 3'd1;
  localparam logic [2:0] DASH_U       = 3'd3;
  localparam logic [2:0] ELEM_GAP_U   = 3'd1;
  localparam logic [2:0] CHAR_GAP_U   = 3'd3;
  localparam logic [2:0] WORD_EXTRA_U = 3'd4;

  localparam logic [3:0] MAX_SLOTS = 4'd12;

  // Sentinel position equals the number of elements that follow it.
  function automatic logic [2:0] sym_len(input logic [4:0] s);
    if (s[4]) return 3'd4;
    if (s[3]) return 3'd3;
    if (s[2]) return 3'd2;
    if (s[1]) return 3'd1;
    return 3'd0;
  endfunction

  // Element bits left-aligned so the next element is always bit 3.
  function automatic logic [3:0] sym_align(input logic [4:0] s);
    return s[3:0] << (3'd4 - sym_len(s));
  endfunction

endpackage

// File: rtl/morse_tx_sequencer_unit_timer.sv
// Unit timer: counts units*UNIT_CYCLES clocks after a load and pulses expire_o
// in the last cycle of that interval.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [2:0] units_i,
  output logic       expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= CNT_W'(units_i) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_q <= 1'b0;
      else             cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: walks the symbol mux select through 1..n_chars and
// keys morse_out with standard dot/dash/gap unit timing.
module morse_tx_sequencer
  import morse_defs::*;
#(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] n_chars,
  input  logic [4:0] simbolo,
  output logic [3:0] sel,
  output logic       morse_out,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [3:0] sel_q;
  logic [3:0] n_q;
  logic [3:0] shreg_q;
  logic [2:0] elem_q;
  logic       morse_q;
  logic       busy_q;
  logic       done_q;

  logic       tmr_load;
  logic [2:0] tmr_units;
  logic       tmr_expire;
  logic [3:0] sym_bits;

  assign sym_bits = sym_align(simbolo);

  // Timer reload mirrors the FSM's entries into timed states, on the same edge.
  always_comb begin
    tmr_units = '0;
    case (state_q)
      ST_LOAD: begin
        if (simbolo == SYM_SPACE)    tmr_units = WORD_EXTRA_U;
        else if (simbolo != SYM_END) tmr_units = sym_bits[3] ? DASH_U : DOT_U;
      end
      ST_ELEM_ON: begin
        if (tmr_expire) tmr_units = (elem_q > 3'd1) ? ELEM_GAP_U : CHAR_GAP_U;
      end
      ST_ELEM_GAP: begin
        if (tmr_expire) tmr_units = shreg_q[3] ? DASH_U : DOT_U;
      end
      default: tmr_units = '0;
    endcase
    tmr_load = (tmr_units != '0);
  end

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (tmr_load),
    .units_i (tmr_units),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      elem_q  <= '0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (n_chars == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              n_q     <= (n_chars > MAX_SLOTS) ? MAX_SLOTS : n_chars;
              sel_q   <= 4'd1;
              busy_q  <= 1'b1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (simbolo == SYM_END) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            sel_q   <= '0;
          end else if (simbolo == SYM_SPACE) begin
            state_q <= ST_WORD_GAP;
          end else begin
            shreg_q <= sym_bits;
            elem_q  <= sym_len(simbolo);
            morse_q <= 1'b1;
            state_q <= ST_ELEM_ON;
          end
        end
        ST_ELEM_ON: begin
          if (tmr_expire) begin
            morse_q <= 1'b0;
            shreg_q <= shreg_q << 1;
            elem_q  <= elem_q - 3'd1;
            state_q <= (elem_q > 3'd1) ? ST_ELEM_GAP : ST_CHAR_GAP;
          end
        end
        ST_ELEM_GAP: begin
          if (tmr_expire) begin
            morse_q <= 1'b1;
            state_q <= ST_ELEM_ON;
          end
        end
        ST_CHAR_GAP, ST_WORD_GAP: begin
          if (tmr_expire) begin
            if (sel_q == n_q) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              sel_q   <= '0;
            end else begin
              sel_q   <= sel_q + 4'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel       = sel_q;
  assign morse_out = morse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
